// File: rtl/bk_pipe_adder.sv
// Pipelined Brent-Kung prefix adder with valid/ready flow control and multi-word carry chaining.
// Prefix levels are split into STAGES register groups; a global stall holds every stage.
module bk_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);
    localparam int LOG    = $clog2(WIDTH);
    localparam int LEVELS = 2 * LOG - 1;
    localparam int BASE   = LEVELS / STAGES;
    localparam int EXTRA  = LEVELS % STAGES;

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] pb;
        logic             cin;
    } stage_t;

    // First level of group s; the leading EXTRA groups take one extra level.
    function automatic int grp_lo(input int s);
        return s * BASE + ((s < EXTRA) ? s : EXTRA);
    endfunction

    function automatic stage_t bk_level(input int l, input stage_t x);
        stage_t y;
        int     d;
        y = x;
        d = (l < LOG) ? (2 << l) : (1 << (2 * LOG - 1 - l));
        for (int i = 0; i < WIDTH; i++) begin
            if ((l < LOG) ? ((i + 1) % d == 0) : (((i + 1) % d == d / 2) && (i >= d))) begin
                y.g[i] = x.g[i] | (x.p[i] & x.g[i-d/2]);
                y.p[i] = x.p[i] & x.p[i-d/2];
            end
        end
        return y;
    endfunction

    logic [STAGES:1] vld_pipe;
    stage_t          stg_q [1:STAGES];
    stage_t          stg_d [1:STAGES];
    stage_t          src;
    logic            advance, accept, chain_block, cin_eff;
    logic            carry_q, carry_known;
    logic [WIDTH-1:0] carry;

    assign out_valid   = vld_pipe[STAGES];
    assign busy        = |vld_pipe;
    assign advance     = ~out_valid | out_ready;
    assign chain_block = in_chain & (busy | ~carry_known);
    assign in_ready    = advance & ~chain_block;
    assign accept      = in_valid & in_ready;
    assign cin_eff     = in_chain ? carry_q : in_cin;

    always_comb begin
        logic [WIDTH-1:0] pb;
        pb      = in_a ^ in_b;
        src     = '0;
        src.pb  = pb;
        src.p   = pb;
        src.g   = in_a & in_b;
        src.g[0] = (in_a[0] & in_b[0]) | (pb[0] & cin_eff);
        src.cin = cin_eff;
    end

    // Each stage applies its own slice of levels to the previous stage's registers.
    always_comb begin : prefix
        stage_t cur;
        stg_d = '{default: '0};
        cur   = src;
        for (int s = 0; s < STAGES; s++) begin
            for (int l = 0; l < LEVELS; l++)
                if (l >= grp_lo(s) && l < grp_lo(s + 1)) cur = bk_level(l, cur);
            stg_d[s+1] = cur;
            cur        = stg_q[s+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe    <= '0;
            carry_q     <= 1'b0;
            carry_known <= 1'b0;
            for (int s = 1; s <= STAGES; s++) stg_q[s] <= '0;
        end else begin
            if (advance) begin
                vld_pipe[1] <= accept;
                if (accept) stg_q[1] <= stg_d[1];
                for (int s = 2; s <= STAGES; s++) begin
                    vld_pipe[s] <= vld_pipe[s-1];
                    if (vld_pipe[s-1]) stg_q[s] <= stg_d[s];
                end
            end
            if (out_valid & out_ready) begin
                carry_q     <= out_cout;
                carry_known <= 1'b1;
            end
        end
    end

    assign carry    = {stg_q[STAGES].g[WIDTH-2:0], stg_q[STAGES].cin};
    assign out_sum  = stg_q[STAGES].pb ^ carry;
    assign out_cout = stg_q[STAGES].g[WIDTH-1];
    assign out_ovf  = carry[WIDTH-1] ^ stg_q[STAGES].g[WIDTH-1];
endmodule

// File: doc/bk_pipe_adder.md
# bk_pipe_adder

Parametrised, pipelined Brent-Kung prefix adder with valid/ready handshaking and multi-word carry chaining. It generalises the fixed 8-bit Brent-Kung adder family to any power-of-two width, inserts a configurable number of register stages into the prefix tree, and can add operands wider than WIDTH as a sequence of beats. It sits between operand producers and result consumers in the datapath, and any stage may stall it.

## Interface
- WIDTH, 32, operand/sum width; power of two, 4..128.
- STAGES, 2, register stages from input acceptance to output; 1..(2*log2(WIDTH)-1).
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  beat accepted when in_valid & in_ready.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in, used when in_chain=0.
- in_chain  input  1  1: carry-in is the stored cout of the previous delivered beat; in_cin ignored.
- out_valid  output  1  result beat available.
- out_ready  input  1  consumer takes the result when out_valid & out_ready.
- out_sum  output  WIDTH  (A + B + cin) mod 2^WIDTH.
- out_cout  output  1  carry out of bit WIDTH-1.
- out_ovf  output  1  signed overflow: cin into MSB XOR cout.
- busy  output  1  any stage holds a valid beat.

## Operation
- Bitwise p = a^b, g = a&b. Bit 0 folds cin into g[0] (g0 | p0&cin). Brent-Kung tree: log2(WIDTH) up-sweep levels and log2(WIDTH)-1 down-sweep levels. sum[i] = p[i] ^ c[i], with c[0] = cin.
- Pipeline registers split the 2*log2(WIDTH)-1 prefix levels into STAGES groups whose sizes differ by at most 1. The first group is the largest. The last register stage drives the outputs directly; outputs have no combinational path from inputs.
- Each stage carries a valid bit plus its p, g and prefix state.
- Flow control is a global stall. advance = ~out_valid | out_ready. When advance=0, all stages hold their state.
- in_ready = advance & ~chain_block.
- chain_block = in_chain & (busy | ~carry_known).
- carry_known sets when a beat is delivered (out_valid & out_ready). It clears on reset.
- carry_q loads out_cout on each delivered beat. Both chained and non-chained beats update it. It resets to 0.
- A chained beat is accepted only when the pipeline is empty, and its cin = carry_q.
- A chained beat offered after reset with no delivered beat stalls until a non-chained beat has been delivered.
- in_valid=0 while advancing inserts a bubble (valid=0) into stage 1.

## Timing
- Latency: a beat accepted at edge k appears at out_valid after edge k+STAGES-1, with no stall. STAGES=1 means the result is registered at the acceptance edge and visible the next cycle.
- Throughput: 1 beat/cycle for non-chained traffic with out_ready=1. Chained beats issue at most 1 per STAGES+1 cycles.
- Reset (async assert, sync-safe deassert handled externally):
  - all valid bits are 0; out_valid, busy, out_sum, out_cout, out_ovf, carry_q and carry_known are 0.
  - in_ready is 1 for the first cycle after deassert if in_chain=0.
  - Reset mid-operation discards all in-flight beats. No output is produced for them.
- out_valid & ~out_ready: out_sum, out_cout and out_ovf are held stable until taken.
- Simultaneous delivery of the last in-flight beat and an offered chained beat: busy is still 1 in that cycle, so the chained beat is accepted the next cycle using the freshly loaded carry_q.
- Wrap-around: the sum is truncated to WIDTH bits and the overflow is reported only via out_cout/out_ovf.

## Test plan
- Basic add, WIDTH=8, STAGES=2: a=0x3C, b=0x55, cin=1 -> after 2 cycles: sum=0x92, cout=0, ovf=1.
- Wrap: WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
- Backpressure, WIDTH=32, STAGES=3:
  - 10 back-to-back beats a=i, b=0xFFFF_FFF0, cin=0, with out_ready low on cycles 4-6.
  - Required: results are in order, none lost or duplicated, held stable while stalled, and in_ready low during the stall.
- Multi-word chain, WIDTH=32:
  - Beat 1 (non-chained): 0xFFFF_FFFF + 0x1, cin=0 -> sum=0, cout=1.
  - Beat 2 (chained): 0x0 + 0x0 -> sum=0x1, cout=0.
  - in_ready stays low for beat 2 until beat 1 is delivered.
- Chain interlock: in_chain=1 on the first beat after reset -> in_ready=0 indefinitely, until a non-chained beat is delivered.
- Reset mid-flight: assert rst_n=0 with 2 beats in flight -> out_valid=0 and busy=0 immediately. After release, no stale beats appear and carry_known=0.
- Randomised sweep over WIDTH={4,16,64} and every legal STAGES value: results must match a reference A+B+cin computed in the bench.
